font_rom: RTL and testbench

Character-generator ROM for the text-mode video path. Maps an 8-bit character code to a 4×8-pixel monochrome glyph packed into 32 bits, with one registered output stage. It sits between the character video memory and the pixel colour mux, which selects bit `(py % 8) * 4 + (px % 4)` of the glyph.

---
 rtl/font_pkg.sv | 48 ++++
 rtl/font_glyph_lut.sv | 25 ++
 rtl/font_rom.sv | 33 +++
 tb/tb_font_rom.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/font_pkg.sv
// Character-generator constants and the printable 4x8 font table.
// Each glyph packs row y into nibble y, LSB = leftmost pixel.
package font_pkg;

    localparam int GLYPH_W = 4;
    localparam int GLYPH_H = 8;

    typedef logic [GLYPH_W*GLYPH_H-1:0] glyph_t;

    localparam logic [7:0] CH_SPACE   = 8'h20;
    localparam logic [7:0] CH_TILDE   = 8'h7E;
    localparam logic [7:0] CH_CHECKER = 8'hFE;
    localparam logic [7:0] CH_SOLID   = 8'hFF;

    localparam glyph_t GLYPH_BLANK       = 32'h00000000;
    localparam glyph_t GLYPH_REPLACEMENT = 32'h0F99999F;
    localparam glyph_t GLYPH_CHECKER     = 32'hA5A5A5A5;
    localparam glyph_t GLYPH_SOLID       = 32'hFFFFFFFF;

    // Indexed by code - 0x20; column 3 is kept clear as spacing.
    localparam glyph_t FONT [0:94] = '{
        GLYPH_BLANK,  32'h02022222, 32'h00000055, 32'h00575750,
        32'h02342162, 32'h05112445, 32'h06552552, 32'h00000022,
        32'h04222224, 32'h01222221, 32'h00527250, 32'h00227220,
        32'h12200000, 32'h00007000, 32'h02000000, 32'h01122244,
        32'h02555552, 32'h07222232, 32'h07112443, 32'h03442443,
        32'h04447555, 32'h03443117, 32'h02553116, 32'h02222447,
        32'h02552552, 32'h03446552, 32'h00200200, 32'h01220020,
        32'h00421240, 32'h00070700, 32'h00124210, 32'h02022443,
        32'h06177752, 32'h05557552, 32'h03553553, 32'h06111116,
        32'h03555553, 32'h07113117, 32'h01113117, 32'h06555116,
        32'h05557555, 32'h07222227, 32'h02544444, 32'h05531355,
        32'h07111111, 32'h05555775, 32'h05577755, 32'h02555552,
        32'h01113553, 32'h06755552, 32'h05533553, 32'h03442116,
        32'h02222227, 32'h07555555, 32'h02555555, 32'h05775555,
        32'h05552555, 32'h02222555, 32'h07112447, 32'h06222226,
        32'h04422211, 32'h03222223, 32'h00000052, 32'h07000000,
        32'h00000021, 32'h06564300, 32'h03555311, 32'h06111600,
        32'h06555644, 32'h06175200, 32'h02227224, 32'h34655600,
        32'h05555311, 32'h07222302, 32'h25444404, 32'h05313511,
        32'h07222223, 32'h05577500, 32'h05555300, 32'h02555200,
        32'h11355300, 32'h44655600, 32'h01113500, 32'h03421600,
        32'h04222722, 32'h06555500, 32'h02555500, 32'h05775500,
        32'h05525500, 32'h34655500, 32'h07124700, 32'h04221224,
        32'h02222222, 32'h01224221, 32'h00006300
    };

endpackage

// File: rtl/font_glyph_lut.sv
// Combinational code-to-glyph lookup; every code maps to a defined glyph.
module font_glyph_lut
    import font_pkg::*;
(
    input  logic [7:0] i_ch,
    output glyph_t     o_glyph
);

    logic [6:0] w_idx;
    logic       w_printable;

    assign w_idx       = i_ch[6:0] - 7'h20;
    assign w_printable = (i_ch >= CH_SPACE) && (i_ch <= CH_TILDE);

    always_comb begin
        o_glyph = GLYPH_REPLACEMENT;
        unique case (1'b1)
            (i_ch == CH_SOLID):   o_glyph = GLYPH_SOLID;
            (i_ch == CH_CHECKER): o_glyph = GLYPH_CHECKER;
            w_printable:          o_glyph = FONT[w_idx];
            default:              o_glyph = GLYPH_REPLACEMENT;
        endcase
    end

endmodule

// File: rtl/font_rom.sv
// Character-generator ROM: glyph lookup behind one registered stage.
// Reset blanks the output asynchronously.
module font_rom
    import font_pkg::*;
#(
    parameter int GLYPH_W = 4,
    parameter int GLYPH_H = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 ch,
    output logic [GLYPH_W*GLYPH_H-1:0] gfx
);

    glyph_t w_glyph;
    glyph_t r_gfx;

    font_glyph_lut u_lut (
        .i_ch    (ch),
        .o_glyph (w_glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gfx <= GLYPH_BLANK;
        end else begin
            r_gfx <= w_glyph;
        end
    end

    assign gfx = r_gfx;

endmodule

// File: tb/tb_font_rom.sv
// Table-driven bench for font_rom with an expected-result queue.
module tb_font_rom;

    typedef struct {
        logic [7:0]  ch;
        logic [31:0] exp;
        bit          prop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ch  = 8'h41;
    logic [31:0] gfx;

    int n_vec = 0;
    int n_err = 0;

    vec_t sb[$];
    vec_t tbl[$];

    font_rom dut (
        .clk (clk),
        .rst (rst),
        .ch  (ch),
        .gfx (gfx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic bit is_desc(input logic [7:0] c);
        return (c == 8'h2C) || (c == 8'h67) || (c == 8'h6A) ||
               (c == 8'h70) || (c == 8'h71) || (c == 8'h79);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input bit ok, input logic [31:0] act);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h, required property not met", nm, act);
        end
    endtask

    task automatic check_out();
        vec_t v;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue, required an entry");
            return;
        end
        v = sb.pop_front();
        if (!v.prop) begin
            cmp($sformatf("ch_%h", v.ch), gfx, v.exp);
        end else begin
            chk($sformatf("nonzero_%h", v.ch), gfx != 32'h0, gfx);
            chk($sformatf("col3_%h", v.ch),
                (gfx & 32'h88888888) == 32'h0, gfx);
            chk($sformatf("row7_%h", v.ch),
                (gfx[31:28] != 4'h0) == is_desc(v.ch), gfx);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic [31:0] e,
                         input bit p);
        @(negedge clk);
        ch = c;
        sb.push_back('{ch: c, exp: e, prop: p});
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        tbl.push_back('{ch: 8'h20, exp: 32'h00000000, prop: 1'b0});
        tbl.push_back('{ch: 8'hFE, exp: 32'hA5A5A5A5, prop: 1'b0});
        tbl.push_back('{ch: 8'hFF, exp: 32'hFFFFFFFF, prop: 1'b0});
        tbl.push_back('{ch: 8'h2D, exp: 32'h00007000, prop: 1'b0});
        tbl.push_back('{ch: 8'h5F, exp: 32'h07000000, prop: 1'b0});
        tbl.push_back('{ch: 8'h7C, exp: 32'h02222222, prop: 1'b0});
        tbl.push_back('{ch: 8'h00, exp: 32'h0F99999F, prop: 1'b0});
        tbl.push_back('{ch: 8'h1F, exp: 32'h0F99999F, prop: 1'b0});
        tbl.push_back('{ch: 8'h7F, exp: 32'h0F99999F, prop: 1'b0});
        tbl.push_back('{ch: 8'h80, exp: 32'h0F99999F, prop: 1'b0});
        tbl.push_back('{ch: 8'hFD, exp: 32'h0F99999F, prop: 1'b0});
        tbl.push_back('{ch: 8'h20, exp: 32'h00000000, prop: 1'b0});

        // reset held with 'A' presented
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            cmp("rst_hold", gfx, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("rst_release_pre_edge", gfx, 32'h0);
        sb.push_back('{ch: 8'h41, exp: 32'h0, prop: 1'b1});
        @(posedge clk);
        #1;
        check_out();

        foreach (tbl[i]) drive(tbl[i].ch, tbl[i].exp, tbl[i].prop);

        for (int c = 8'h21; c <= 8'h7E; c++) begin
            drive(8'(c), 32'h0, 1'b1);
        end

        // asynchronous clear in the middle of a stream
        drive(8'hFF, 32'hFFFFFFFF, 1'b0);
        drive(8'hFF, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("async_clr", gfx, 32'h0);
        @(posedge clk);
        #1;
        cmp("async_hold", gfx, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("async_release_pre_edge", gfx, 32'h0);
        sb.push_back('{ch: 8'hFF, exp: 32'hFFFFFFFF, prop: 1'b0});
        @(posedge clk);
        #1;
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
